mem_block_mover: RTL
====================

Name: mem_block_mover

Overview:
- Bus initiator for the data-memory port: MEMRead/MEMWrite/ADDR/WD out, RD in.
- Performs block copy (memory-to-memory) or block fill (constant) of up to 1024 words without CPU involvement.
- Sits beside the CPU load/store path; its outputs are muxed onto the data-memory port while busy=1 (the mux is outside this block).
- Honours the memory's 1-cycle registered read latency: RD is valid only in the cycle after MEMRead=1.

Parameters:
- MAX_LEN, 1024, maximum words per transfer; len above this is clamped to MAX_LEN.
- LEN_W, 11, width of len and words_done (must hold MAX_LEN).

Ports:
- clk_50  input  1  system clock, all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE, ignored while busy.
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  32  byte address of the copy source; bits [1:0] are ignored.
- dst_addr  input  32  byte address of the destination; bits [1:0] are ignored.
- len  input  LEN_W  number of words to move, 0 to MAX_LEN.
- fill_val  input  32  word written in fill mode.
- abort  input  1  stop request, level-sampled while busy.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle.
- done  output  1  one-cycle pulse when a transfer ends.
- aborted  output  1  valid with done; high if the transfer ended due to abort.
- words_done  output  LEN_W  count of words written in the current/last transfer.
- checksum  output  32  see Optional Feature.
- MEMRead  output  1  memory read strobe.
- MEMWrite  output  1  memory write strobe.
- ADDR  output  32  memory byte address.
- WD  output  32  memory write data.
- RD  input  32  memory read data, valid the cycle after MEMRead.

Behaviour:
- Reset (asynchronous): state=IDLE. busy, done, aborted, words_done, checksum, MEMRead, MEMWrite, ADDR and WD are all 0.
- Reset mid-transfer drops MEMRead/MEMWrite immediately. No partial write is issued after reset.
- Bus outputs are decoded from the state and pointer registers only.
- In IDLE and DONE: MEMRead=0, MEMWrite=0, ADDR=0, WD=0.
- Start is accepted in IDLE when start=1:
  - Latch src/dst with bits [1:0] forced to 0.
  - Latch len, clamped to MAX_LEN; latch mode and fill_val.
  - Clear words_done, checksum and aborted.
  - Set direction.
- Direction: descending when mode=0 AND dst>src AND dst < src+4*len (32-bit compare). Otherwise ascending.
  - Descending start pointers are src+4*(len-1) and dst+4*(len-1), with step -4. Ascending step is +4.
  - Pointer arithmetic is 32-bit, wrapping modulo 2^32.
- State machine:
  - IDLE -> DONE if len==0.
  - IDLE -> READ if mode=0.
  - IDLE -> WRITE if mode=1.
  - READ: MEMRead=1, ADDR=src_ptr. Next state is always WRITE.
  - WRITE: MEMWrite=1, ADDR=dst_ptr.
    - WD = RD in copy mode (passed through combinationally), WD = fill_val in fill mode.
    - At the edge: words_done+1 and both pointers step.
    - Next state is DONE if the remaining count reaches 0 or abort=1. Otherwise READ (copy) or WRITE (fill).
  - DONE: done=1 for one cycle, busy=0. Next state is IDLE.
- Abort sampled in READ: the read completes, and the following WRITE for that word still completes, then DONE with aborted=1.
- Abort sampled in WRITE: the current write completes, then DONE.
- words_done is exact at done.
- Latency, with start sampled at edge 0:
  - Copy of N words: bus cycles 1..2N, done in cycle 2N+1.
  - Fill of N words: bus cycles 1..N, done in cycle N+1.
  - len=0: done in cycle 1, no bus activity, busy never asserted.
- start and abort asserted in the same cycle while in IDLE: start is accepted and abort is ignored. Abort is only sampled while busy.
- MEMRead and MEMWrite are never both 1 in the same cycle.

Optional Feature:
- Macro: MEM_MOVER_CHECKSUM_EN.
- Defined: checksum accumulates the 32-bit wrap-around sum of every WD value written. It is cleared on start and holds its value after done until the next start.
- Not defined: checksum is tied to 0 and no adder is synthesized.

Test Plan:
- Copy: memory words 0..3 = 1,2,3,4; src=0x0, dst=0x100, len=4, start at edge 0.
  - Result: words 64..67 = 1,2,3,4; done in cycle 9; words_done=4; checksum=10 (with macro).
- Fill: dst=0x40, len=3, fill_val=0xDEADBEEF.
  - Result: words 16..18 = 0xDEADBEEF; three consecutive MEMWrite cycles; done in cycle 4; MEMRead never high.
- Overlap: words 0..3 = 1,2,3,4; src=0x0, dst=0x4, len=4.
  - Result: ADDR sequence is read 0xC, write 0x10, read 0x8, ...; final words 1..4 = 1,2,3,4.
- Abort: copy with len=8; abort high in cycle 5 (a READ cycle).
  - Result: the word read in cycle 5 is written in cycle 6; done in cycle 7; aborted=1; words_done=3.
- Edge cases:
  - len=0: done in cycle 1, busy stays 0.
  - start pulsed while busy: ignored.
  - len=2000: clamped, 1024 words moved.
- Reset mid-op: rst asserted during a WRITE cycle of a copy.
  - Result: MEMWrite falls without waiting for a clock edge; all outputs read 0; next start begins a fresh transfer.

Source files
------------

// File: rtl/mem_block_mover_if.sv
// Bundles the request, status and data-memory bus signals of the block mover.
// The master side is the mover; the slave side is the CPU/memory environment.
interface mem_block_mover_if #(
  parameter int LEN_W = 11
);
  logic             start;
  logic             mode;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic [31:0]      fill_val;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] words_done;
  logic [31:0]      checksum;
  logic             MEMRead;
  logic             MEMWrite;
  logic [31:0]      ADDR;
  logic [31:0]      WD;
  logic [31:0]      RD;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_val, abort, RD,
    output busy, done, aborted, words_done, checksum, MEMRead, MEMWrite, ADDR, WD
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_val, abort, RD,
    input  busy, done, aborted, words_done, checksum, MEMRead, MEMWrite, ADDR, WD
  );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / fill engine driving the data-memory port (1-cycle read latency).
// Optional macro MEM_MOVER_CHECKSUM_EN enables a running sum of written words.
module mem_block_mover #(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11
) (
  input  logic               clk_50,
  input  logic               rst,
  mem_block_mover_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_ptr_q, dst_ptr_q, step_q, fill_q;
  logic [LEN_W-1:0] rem_q, wdone_q;
  logic             mode_q, abort_pend_q, aborted_q;

  logic [LEN_W-1:0] len_c;
  logic [31:0]      src_a, dst_a, span;
  logic             desc, start_go, stop;
  logic [31:0]      wd_val;

  // Request decode: clamp length, align addresses, pick copy direction so
  // an overlapping forward move does not overwrite unread source words.
  always_comb begin
    len_c    = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
    src_a    = bus.src_addr & 32'hFFFF_FFFC;
    dst_a    = bus.dst_addr & 32'hFFFF_FFFC;
    span     = {{(32-LEN_W-2){1'b0}}, len_c, 2'b00};
    desc     = !bus.mode && (dst_a > src_a) && (dst_a < src_a + span);
    start_go = (state_q == S_IDLE) && bus.start;
    stop     = (rem_q == LEN_W'(1)) || bus.abort || abort_pend_q;
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (len_c == '0) ? S_DONE :
                                        (bus.mode ? S_WRITE : S_READ);
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = stop ? S_DONE : (mode_q ? S_WRITE : S_READ);
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wd_val = mode_q ? fill_q : bus.RD;

  always_comb begin
    bus.MEMRead  = 1'b0;
    bus.MEMWrite = 1'b0;
    bus.ADDR     = '0;
    bus.WD       = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      S_READ: begin
        bus.MEMRead = 1'b1;
        bus.ADDR    = src_ptr_q;
        bus.busy    = 1'b1;
      end
      S_WRITE: begin
        bus.MEMWrite = 1'b1;
        bus.ADDR     = dst_ptr_q;
        bus.WD       = wd_val;
        bus.busy     = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      step_q       <= '0;
      fill_q       <= '0;
      rem_q        <= '0;
      wdone_q      <= '0;
      mode_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (start_go) begin
      src_ptr_q    <= desc ? src_a + span - 32'd4 : src_a;
      dst_ptr_q    <= desc ? dst_a + span - 32'd4 : dst_a;
      step_q       <= desc ? 32'hFFFF_FFFC : 32'd4;
      fill_q       <= bus.fill_val;
      rem_q        <= len_c;
      wdone_q      <= '0;
      mode_q       <= bus.mode;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (state_q == S_READ) begin
      // The word already being read still gets written before stopping.
      if (bus.abort) abort_pend_q <= 1'b1;
    end else if (state_q == S_WRITE) begin
      src_ptr_q <= src_ptr_q + step_q;
      dst_ptr_q <= dst_ptr_q + step_q;
      rem_q     <= rem_q - LEN_W'(1);
      wdone_q   <= wdone_q + LEN_W'(1);
      if (stop) aborted_q <= bus.abort || abort_pend_q;
    end
  end

  assign bus.words_done = wdone_q;
  assign bus.aborted    = aborted_q;

`ifdef MEM_MOVER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)                        checksum_q <= '0;
    else if (start_go)              checksum_q <= '0;
    else if (state_q == S_WRITE)    checksum_q <= checksum_q + wd_val;
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule
